// File: rtl/fdt_update_gen_pkg.sv
// ---------------------------------------------------------------------------
// fdt_update_gen_pkg
// Shared widths, size-class bit positions, queue entry type and pacing FSM
// state encoding for the FDT update generator and its row-summary helper.
// No ports.
// ---------------------------------------------------------------------------
package fdt_update_gen_pkg;

  // Find-table row index and per-row size-class vector widths
  localparam int FDT_INDEX_WIDTH = 6;
  localparam int FDT_BIT_WIDTH   = 4;

  // Size-class bit positions inside the update vector (1 = no free block of that class)
  localparam int FDT_BIT_512 = 0;
  localparam int FDT_BIT_1K  = 1;
  localparam int FDT_BIT_2K  = 2;
  localparam int FDT_BIT_4K  = 3;

  // 512B leaves per 4K row; the summary logic is written for exactly 8
  localparam int LEAF_NUM = 8;

  // One pending update: which row, and its summarised size-class vector
  typedef struct packed {
    logic [FDT_INDEX_WIDTH-1:0] idx;
    logic [FDT_BIT_WIDTH-1:0]   bits;
  } fdt_entry_t;

  // Pacing FSM: ISSUE is the cycle the strobe is on the wire, WAIT burns the gap
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pace_state_e;

endpackage

// File: rtl/fdt_update_gen_if.sv
// ---------------------------------------------------------------------------
// fdt_update_gen_if
// Groups the row-report handshake (AT tree -> generator) and the find-table
// update bus (generator -> find table) plus the queue level.
//   master : AT-tree / find-table side (drives reports, observes updates)
//   slave  : fdt_update_gen
// Parameter FIFO_DEPTH sizes fifo_level_out ($clog2(FIFO_DEPTH)+1 bits).
// ---------------------------------------------------------------------------
interface fdt_update_gen_if
  import fdt_update_gen_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                       row_upd_valid_in;
  logic                       row_upd_ready_out;
  logic [FDT_INDEX_WIDTH-1:0] row_upd_idx_in;
  logic [LEAF_NUM-1:0]        row_upd_occ_in;
  logic                       fdt_update_valid_at_out;
  logic [FDT_INDEX_WIDTH-1:0] fdt_update_idx_at_out;
  logic [FDT_BIT_WIDTH-1:0]   fdt_update_bit_sequence_out;
  logic [LVL_W-1:0]           fifo_level_out;

  modport master (
    output row_upd_valid_in, row_upd_idx_in, row_upd_occ_in,
    input  row_upd_ready_out, fdt_update_valid_at_out, fdt_update_idx_at_out,
    input  fdt_update_bit_sequence_out, fifo_level_out
  );

  modport slave (
    input  row_upd_valid_in, row_upd_idx_in, row_upd_occ_in,
    output row_upd_ready_out, fdt_update_valid_at_out, fdt_update_idx_at_out,
    output fdt_update_bit_sequence_out, fifo_level_out
  );

endinterface

// File: rtl/fdt_update_gen_row_summary.sv
// ---------------------------------------------------------------------------
// fdt_row_summary
// Pure combinational reduction of an 8-leaf occupancy map into the 4-bit
// size-class "full" vector. Reusable by the AT-tree checker.
//   occ_i  [LEAF_NUM]      : 1 = leaf in use
//   bits_o [FDT_BIT_WIDTH] : [0]512 [1]1K [2]2K [3]4K, 1 = no free block of class
// ---------------------------------------------------------------------------
module fdt_row_summary
  import fdt_update_gen_pkg::*;
(
  input  logic [LEAF_NUM-1:0]      occ_i,
  output logic [FDT_BIT_WIDTH-1:0] bits_o
);

  logic pair_free_s;
  logic nib_free_s;

  // Look for an aligned all-free 1K pair / 2K nibble and fold into the class vector
  always_comb begin
    pair_free_s = 1'b0;
    nib_free_s  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pair_free_s = pair_free_s | (occ_i[2*i +: 2] == 2'b00);
    end
    for (int j = 0; j < 2; j++) begin
      nib_free_s = nib_free_s | (occ_i[4*j +: 4] == 4'b0000);
    end
    bits_o              = {FDT_BIT_WIDTH{1'b0}};
    bits_o[FDT_BIT_512] = &occ_i;
    bits_o[FDT_BIT_1K]  = ~pair_free_s;
    bits_o[FDT_BIT_2K]  = ~nib_free_s;
    // A 4K block is only free when the whole row is empty
    bits_o[FDT_BIT_4K]  = |occ_i;
  end

endmodule

// File: rtl/fdt_update_gen.sv
// ---------------------------------------------------------------------------
// fdt_update_gen
// Source end of the FDT update interface. Accepts per-row leaf-occupancy
// reports, summarises each into a size-class vector, queues it, and issues
// paced single-cycle update strobes to the find table in acceptance order.
//   clk, rst_n (async, active-low)
//   bus (fdt_update_gen_if.slave): report handshake in, update strobe out,
//       queue level out.
// Parameters: FIFO_DEPTH (power of 2, >=2), MIN_GAP (>=1 cycles between strobes).
// Optional build macro FDT_UPD_COALESCE_EN: a report whose row is already
// queued (and not being popped this cycle) overwrites that entry in place.
// ---------------------------------------------------------------------------
module fdt_update_gen
  import fdt_update_gen_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 3
)
(
  input  logic           clk,
  input  logic           rst_n,
  fdt_update_gen_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  fdt_entry_t                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]           level_q, level_d;
  logic                       full_q;

  pace_state_e                state_q, state_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic                       valid_q, valid_d;
  logic [FDT_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [FDT_BIT_WIDTH-1:0]   bits_q, bits_d;

  logic [FDT_BIT_WIDTH-1:0]   sum_s;
  logic                       empty_s, pop_s, accept_s, push_s, hit_s, ready_s;
  fdt_entry_t                 head_s;

  fdt_row_summary u_summary (
    .occ_i  (bus.row_upd_occ_in),
    .bits_o (sum_s)
  );

  assign empty_s = (level_q == {LVL_W{1'b0}});
  assign head_s  = mem_q[rd_ptr_q];

`ifdef FDT_UPD_COALESCE_EN
  logic [PTR_W-1:0] hit_slot_s;

  // Match the incoming row against live entries; the head being popped right now is excluded
  always_comb begin
    logic [PTR_W-1:0] slot_v;
    logic [PTR_W-1:0] off_v;
    hit_s      = 1'b0;
    hit_slot_s = {PTR_W{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_v = PTR_W'(i);
      off_v  = slot_v - rd_ptr_q;
      if (({1'b0, off_v} < level_q) &&
          (mem_q[i].idx == bus.row_upd_idx_in) &&
          !(pop_s && (slot_v == rd_ptr_q))) begin
        hit_s      = 1'b1;
        hit_slot_s = slot_v;
      end else begin
        hit_s      = hit_s;
        hit_slot_s = hit_slot_s;
      end
    end
  end

  // A matching report never needs a slot, so it may be taken even when full
  assign ready_s = ~full_q | hit_s;
`else
  assign hit_s   = 1'b0;
  assign ready_s = ~full_q;
`endif

  assign accept_s = bus.row_upd_valid_in & ready_s;
  assign push_s   = accept_s & ~hit_s;

  // Queue occupancy next state; push and pop together leave it unchanged
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pending-update queue storage, pointers and level/full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      full_q   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= '{idx: bus.row_upd_idx_in, bits: sum_s};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
`ifdef FDT_UPD_COALESCE_EN
      if (accept_s && hit_s) begin
        mem_q[hit_slot_s].bits <= sum_s;
      end
`endif
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
    end
  end

  // Pacing FSM: pop when allowed, strobe next cycle, then hold off MIN_GAP-1 cycles
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop_s   = 1'b0;
    valid_d = 1'b0;
    idx_d   = idx_q;
    bits_d  = bits_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          valid_d = 1'b1;
          idx_d   = head_s.idx;
          bits_d  = head_s.bits;
          gap_d   = GAP_LOAD;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (gap_q != {GAP_W{1'b0}}) begin
          gap_d   = gap_q - GAP_W'(1);
          state_d = ST_WAIT;
        end else if (!empty_s) begin
          pop_s   = 1'b1;
          valid_d = 1'b1;
          idx_d   = head_s.idx;
          bits_d  = head_s.bits;
          gap_d   = GAP_LOAD;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        gap_d   = {GAP_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pacing state and registered update outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= {GAP_W{1'b0}};
      valid_q <= 1'b0;
      idx_q   <= {FDT_INDEX_WIDTH{1'b0}};
      bits_q  <= {FDT_BIT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
    end
  end

  assign bus.row_upd_ready_out           = ready_s;
  assign bus.fdt_update_valid_at_out     = valid_q;
  assign bus.fdt_update_idx_at_out       = idx_q;
  assign bus.fdt_update_bit_sequence_out = bits_q;
  assign bus.fifo_level_out              = level_q;

endmodule
